// File: rtl/instruction_decode_queue.sv
// Instruction queue with enqueue-time opcode classification and a CEX predication
// FSM that marks the instructions following a CEX as executed or squashed.
module instruction_decode_queue #(
  parameter int unsigned WORD  = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [WORD-1:0] in_inst,
  input  logic [WORD-1:0] in_pc,
  input  logic [3:0]      status,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WORD-1:0] out_inst,
  output logic [WORD-1:0] out_pc,
  output logic [3:0]      out_opcode,
  output logic            out_exec,
  output logic            cex_active
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [3:0] OP_BL    = 4'd0;
  localparam logic [3:0] OP_BC    = 4'd1;
  localparam logic [3:0] OP_ALU   = 4'd2;
  localparam logic [3:0] OP_SHIFT = 4'd3;
  localparam logic [3:0] OP_SWAP  = 4'd4;
  localparam logic [3:0] OP_LD    = 4'd5;
  localparam logic [3:0] OP_CEX   = 4'd8;
  localparam logic [3:0] OP_MOVI  = 4'd9;
  localparam logic [3:0] OP_LDR   = 4'd10;
  localparam logic [3:0] OP_STR   = 4'd11;

  typedef enum logic [1:0] {IDLE, TBLK, FBLK} state_t;

  // Opcode class from the top bits of the instruction word.
  function automatic logic [3:0] decode(input logic [15:0] i);
    logic [3:0] op;
    op = OP_STR;
    if (i[15:14] == 2'b00) begin
      op = i[13] ? OP_BC : OP_BL;
    end else if (i[15:12] == 4'b0100) begin
      if (i[11:8] == 4'b1100)                           op = OP_SWAP;
      else if (i[11:8] == 4'b1101 || i[11:8] == 4'b1110) op = OP_SHIFT;
      else                                               op = OP_ALU;
    end else if (i[15:12] == 4'b0101) begin
      op = OP_LD + {2'b00, i[11:10]};
    end else if (i[15:13] == 3'b011) begin
      op = OP_MOVI;
    end else if (i[15:14] == 2'b10) begin
      op = OP_LDR;
    end
    return op;
  endfunction

  // Condition evaluation against status = {V,N,Z,C}.
  function automatic logic cond_true(input logic [3:0] cc, input logic [3:0] s);
    logic v, n, z, c, r;
    {v, n, z, c} = s;
    case (cc)
      4'd0:    r = z;
      4'd1:    r = !z;
      4'd2:    r = c;
      4'd3:    r = !c;
      4'd4:    r = n;
      4'd5:    r = !n;
      4'd6:    r = v;
      4'd7:    r = !v;
      4'd8:    r = c & !z;
      4'd9:    r = !c | z;
      4'd10:   r = (n == v);
      4'd11:   r = (n != v);
      4'd12:   r = !z & (n == v);
      4'd13:   r = z | (n != v);
      4'd14:   r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  logic [WORD-1:0] inst_mem [DEPTH];
  logic [WORD-1:0] pc_mem   [DEPTH];
  logic [3:0]      op_mem   [DEPTH];
  logic [AW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  logic            push, pop;

  state_t     state, state_n;
  logic       res, res_n;
  logic [2:0] tcnt_r, tcnt_n, fcnt_r, fcnt_n;

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Storage has no reset; pointers and count alone define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= in_inst;
      pc_mem[wr_ptr]   <= in_pc;
      op_mem[wr_ptr]   <= decode(in_inst[15:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Predication state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      res    <= 1'b0;
      tcnt_r <= '0;
      fcnt_r <= '0;
    end else begin
      state  <= state_n;
      res    <= res_n;
      tcnt_r <= tcnt_n;
      fcnt_r <= fcnt_n;
    end
  end

  // Next-state: the FSM only moves on a pop; flush abandons any block.
  always_comb begin
    state_n = state;
    res_n   = res;
    tcnt_n  = tcnt_r;
    fcnt_n  = fcnt_r;
    if (pop) begin
      case (state)
        IDLE: begin
          if (op_mem[rd_ptr] == OP_CEX) begin
            res_n  = cond_true(inst_mem[rd_ptr][9:6], status);
            tcnt_n = inst_mem[rd_ptr][5:3];
            fcnt_n = inst_mem[rd_ptr][2:0];
            if (inst_mem[rd_ptr][5:3] != 3'd0)      state_n = TBLK;
            else if (inst_mem[rd_ptr][2:0] != 3'd0) state_n = FBLK;
          end
        end
        TBLK: begin
          tcnt_n = tcnt_r - 3'd1;
          if (tcnt_r == 3'd1) state_n = (fcnt_r != 3'd0) ? FBLK : IDLE;
        end
        FBLK: begin
          fcnt_n = fcnt_r - 3'd1;
          if (fcnt_r == 3'd1) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
    if (flush) state_n = IDLE;
  end

  assign cex_active = (state != IDLE);
  assign out_inst   = out_valid ? inst_mem[rd_ptr] : '0;
  assign out_pc     = out_valid ? pc_mem[rd_ptr]   : '0;
  assign out_opcode = out_valid ? op_mem[rd_ptr]   : 4'd0;

  always_comb begin
    out_exec = 1'b1;
    if (out_valid) begin
      case (state)
        TBLK:    out_exec = res;
        FBLK:    out_exec = !res;
        default: out_exec = 1'b1;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_decode_queue.sv
// Bench for instruction_decode_queue: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a queue-based reference model.
module tb_instruction_decode_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic [15:0] in_inst, in_pc;
  logic [3:0]  status;
  logic        in_ready, out_valid, out_exec, cex_active;
  logic [15:0] out_inst, out_pc;
  logic [3:0]  out_opcode;

  instruction_decode_queue #(.WORD(16), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .status(status),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_exec(out_exec), .cex_active(cex_active)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;
  logic [15:0] pc_next = 16'h0100;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [15:0] inst; logic [15:0] pc; } ent_t;
  ent_t q[$];
  int   mode = 0;          // 0 none, 1 taken block, 2 not-taken block
  bit   m_res = 0;
  int   m_tc = 0, m_fc = 0;

  function automatic logic [3:0] m_decode(input logic [15:0] i);
    casez (i[15:8])
      8'b001?_????: return 4'd1;
      8'b000?_????: return 4'd0;
      8'b0100_1100: return 4'd4;
      8'b0100_1101,
      8'b0100_1110: return 4'd3;
      8'b0100_????: return 4'd2;
      8'b0101_00??: return 4'd5;
      8'b0101_01??: return 4'd6;
      8'b0101_10??: return 4'd7;
      8'b0101_11??: return 4'd8;
      8'b011?_????: return 4'd9;
      8'b10??_????: return 4'd10;
      default:      return 4'd11;
    endcase
  endfunction

  // Conditions come in pairs: odd codes are the negation of the even one below.
  function automatic bit m_cond(input logic [3:0] cc, input logic [3:0] s);
    bit v, n, z, c, base;
    {v, n, z, c} = s;
    case (cc[3:1])
      3'd0: base = z;
      3'd1: base = c;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = c && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    return base ^ cc[0];
  endfunction

  always @(posedge clk) begin
    bit do_push, do_pop;
    ent_t h;
    if (rst) begin
      q.delete(); mode = 0; m_res = 0; m_tc = 0; m_fc = 0;
    end else if (flush) begin
      q.delete(); mode = 0;
    end else begin
      do_push = in_valid && (q.size() < DEPTH);
      do_pop  = out_ready && (q.size() > 0);
      if (do_pop) begin
        h = q.pop_front();
        if (mode == 0) begin
          if (m_decode(h.inst) == 4'd8) begin
            m_res = m_cond(h.inst[9:6], status);
            m_tc = int'(h.inst[5:3]);
            m_fc = int'(h.inst[2:0]);
            mode = (m_tc > 0) ? 1 : (m_fc > 0) ? 2 : 0;
          end
        end else if (mode == 1) begin
          m_tc--;
          if (m_tc == 0) mode = (m_fc > 0) ? 2 : 0;
        end else begin
          m_fc--;
          if (m_fc == 0) mode = 0;
        end
      end
      if (do_push) q.push_back(ent_t'({in_inst, in_pc}));
    end
  end

  // Compare process: every cycle after the initial reset.
  always @(negedge clk) begin
    bit ev;
    if (chk_en) begin
      ev = (q.size() == 0) ? 1'b1 : (mode == 1) ? m_res : (mode == 2) ? !m_res : 1'b1;
      chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
      chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
      chk("out_inst", 32'(out_inst), (q.size() > 0) ? 32'(q[0].inst) : 32'd0);
      chk("out_pc", 32'(out_pc), (q.size() > 0) ? 32'(q[0].pc) : 32'd0);
      chk("out_opcode", 32'(out_opcode), (q.size() > 0) ? 32'(m_decode(q[0].inst)) : 32'd0);
      chk("out_exec", 32'(out_exec), 32'(ev));
      chk("cex_active", 32'(cex_active), 32'(mode != 0));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic enq(input logic [15:0] inst);
    in_valid = 1'b1; in_inst = inst; in_pc = pc_next; pc_next += 16'd2;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0; status = '0;
    tick(); tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_exec", 32'(out_exec), 32'd1);
    chk("rst_cex_active", 32'(cex_active), 32'd0);
    chk("rst_out_inst", 32'(out_inst), 32'd0);

    // Single push, one-cycle latency
    in_valid = 1'b1; in_inst = 16'h4000; in_pc = 16'h0100;
    tick();
    in_valid = 1'b0;
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_opcode", 32'(out_opcode), 32'd2);
    chk("single_pc", 32'(out_pc), 32'h0100);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Fill to full, fifth push held, FIFO order
    for (int i = 0; i < 4; i++) enq(16'h4000 | 16'(i));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    enq(16'h4004);
    chk("held_in_ready", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("fifo_order", 32'(out_inst), 32'(16'h4000 | 16'(i)));
      tick();
    end
    chk("drained_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;

    // CEX cond Z with Z=0: exec 1,0,1,1
    status = 4'b0001;
    enq(16'h5C0A); enq(16'h4000); enq(16'h4100); enq(16'h4200);
    out_ready = 1'b1;
    chk("cex_exec0", 32'(out_exec), 32'd1); tick();
    chk("cex_active_on", 32'(cex_active), 32'd1);
    chk("cex_exec1", 32'(out_exec), 32'd0); tick();
    chk("cex_exec2", 32'(out_exec), 32'd1); tick();
    chk("cex_exec3", 32'(out_exec), 32'd1);
    chk("cex_active_3rd", 32'(cex_active), 32'd1); tick();
    chk("cex_active_off", 32'(cex_active), 32'd0);
    out_ready = 1'b0;

    // CEX with empty blocks stays idle
    enq(16'h5F80);
    out_ready = 1'b1;
    chk("cex0_exec", 32'(out_exec), 32'd1); tick();
    chk("cex0_idle", 32'(cex_active), 32'd0);
    out_ready = 1'b0;

    // Flush in TBLK with 3 entries and a pending push
    enq(16'h5FB8); enq(16'h4000); enq(16'h4100); enq(16'h4200);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("pre_flush_tblk", 32'(cex_active), 32'd1);
    flush = 1'b1; in_valid = 1'b1; in_inst = 16'h6123; tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_cex", 32'(cex_active), 32'd0);
    tick();
    chk("flush_no_enq", 32'(out_valid), 32'd0);

    // Reset mid-FBLK with full queue
    enq(16'h5F87); enq(16'h4000); enq(16'h4100); enq(16'h4200);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    enq(16'h4300);
    chk("pre_rst_full", 32'(in_ready), 32'd0);
    chk("pre_rst_fblk", 32'(cex_active), 32'd1);
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1; tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_ready", 32'(in_ready), 32'd1);
    chk("rst_mid_cex", 32'(cex_active), 32'd0);

    // Decode spot checks
    enq(16'h0A00); enq(16'h2A00); enq(16'h4D00); enq(16'h4C00);
    out_ready = 1'b1;
    chk("dec_bl", 32'(out_opcode), 32'd0); tick();
    chk("dec_bc", 32'(out_opcode), 32'd1); tick();
    chk("dec_shift", 32'(out_opcode), 32'd3); tick();
    chk("dec_swap", 32'(out_opcode), 32'd4); tick();
    out_ready = 1'b0;

    // Randomized traffic
    for (int c = 0; c < 4000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      status    = 4'($urandom);
      flush     = ($urandom_range(0, 59) == 0);
      rst       = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 4) == 0) in_inst = {6'b010111, 10'($urandom)};
      else                           in_inst = 16'($urandom);
      in_pc = pc_next; pc_next += 16'd2;
      tick();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
